// File: rtl/pwm_decode_if.sv
// PWM decoder connection bundle: enable and raw PWM pin toward the decoder,
// measured period/high time and strobes back to the control logic.
`timescale 1ns/1ps

interface pwm_decode_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             sig_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             ovf_o;
  logic             level_o;

  modport master (
    output en,
    output sig_i,
    input  period_o,
    input  high_o,
    input  valid_o,
    input  ovf_o,
    input  level_o
  );

  modport slave (
    input  en,
    input  sig_i,
    output period_o,
    output high_o,
    output valid_o,
    output ovf_o,
    output level_o
  );
endinterface

// File: rtl/pwm_decode.sv
// Measures period and high time of an asynchronous PWM input in clk cycles,
// publishing one result per complete period with a single-cycle valid strobe.
`timescale 1ns/1ps

module pwm_decode #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pwm_decode_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_d;
  logic                   rise;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       high_cnt;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       high_q;
  logic                   valid_q;
  logic                   ovf_q;
  logic                   level_q;

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_i};
      sig_d  <= sig_s;
    end
  end

  // A rise is checked before saturation so a period of exactly all-ones is
  // still published; a saturated counter with no rise reports overflow instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      if (!bus.en) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            period_cnt <= '0;
            high_cnt   <= '0;
            state      <= ARM;
          end
          ARM: begin
            if (rise) begin
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
              state      <= MEAS;
            end
          end
          MEAS: begin
            if (rise) begin
              period_q   <= period_cnt;
              high_q     <= high_cnt;
              valid_q    <= 1'b1;
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
            end else if (period_cnt == CNT_MAX) begin
              ovf_q      <= 1'b1;
              level_q    <= sig_s;
              period_cnt <= '0;
              high_cnt   <= '0;
              state      <= ARM;
            end else begin
              period_cnt <= period_cnt + CNT_ONE;
              high_cnt   <= high_cnt + {{(CNT_W-1){1'b0}}, sig_s};
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.period_o = period_q;
  assign bus.high_o   = high_q;
  assign bus.valid_o  = valid_q;
  assign bus.ovf_o    = ovf_q;
  assign bus.level_o  = level_q;

endmodule

// File: tb/tb_pwm_decode.sv
// Directed bench for pwm_decode: drives PWM patterns on the pin and checks every
// strobe against a queue of expected results stamped with their arrival cycle.
`timescale 1ns/1ps

module tb_pwm_decode;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int SAT         = (1 << CNT_W) - 1;

  typedef struct {
    bit               is_ovf;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             level;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   strobe_count = 0;
  exp_t exp_q[$];
  bit   have_prev = 1'b0;
  int   prev_p = 0;
  int   prev_h = 0;
  int   last_rise = 0;

  pwm_decode_if #(.CNT_W(CNT_W)) bus ();

  pwm_decode #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_valid(input int p, input int h, input int c);
    exp_t e;
    e.is_ovf = 1'b0;
    e.period = CNT_W'(p);
    e.high   = CNT_W'(h);
    e.level  = 1'b0;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  task automatic push_ovf(input logic lvl, input int c);
    exp_t e;
    e.is_ovf = 1'b1;
    e.period = '0;
    e.high   = '0;
    e.level  = lvl;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  // Each rise publishes the period that ended just before it, if one was tracked.
  task automatic apply_stimulus(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      last_rise = cycle;
      if (have_prev) push_valid(prev_p, prev_h, last_rise + LAT);
      bus.sig_i = 1'b1;
      step(h);
      bus.sig_i = 1'b0;
      step(p - h);
      have_prev = 1'b1;
      prev_p    = p;
      prev_h    = h;
    end
  endtask

  task automatic check_hold(input string tag, input int p, input int h);
    check_output({tag, "_period"}, 32'(bus.period_o), p);
    check_output({tag, "_high"}, 32'(bus.high_o), h);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.valid_o || bus.ovf_o) begin
      strobe_count++;
      check_output("strobe_exclusive", 32'(bus.valid_o && bus.ovf_o), 0);
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("[TB] FAIL unexpected_strobe: observed valid=%0d ovf=%0d at cycle %0d expected none",
               bus.valid_o, bus.ovf_o, cycle);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("strobe_kind_ovf", 32'(bus.ovf_o), 32'(e.is_ovf));
        check_output("strobe_cycle", cycle, e.cyc);
        if (e.is_ovf) begin
          check_output("ovf_level", 32'(bus.level_o), 32'(e.level));
        end else begin
          check_output("valid_period", 32'(bus.period_o), 32'(e.period));
          check_output("valid_high", 32'(bus.high_o), 32'(e.high));
          check_output("high_below_period", 32'(bus.high_o < bus.period_o), 1);
        end
      end
    end
  end

  initial begin
    int c;
    int s0;
    bus.en    = 1'b0;
    bus.sig_i = 1'b0;
    rst       = 1'b0;
    step(3);
    check_output("reset_period", 32'(bus.period_o), 0);
    check_output("reset_high", 32'(bus.high_o), 0);
    check_output("reset_valid", 32'(bus.valid_o), 0);
    check_output("reset_ovf", 32'(bus.ovf_o), 0);
    check_output("reset_level", 32'(bus.level_o), 0);

    rst    = 1'b1;
    bus.en = 1'b1;
    step(3);

    $display("[TB] loopback 10/4 then duty change to 10/7");
    apply_stimulus(10, 4, 6);
    apply_stimulus(10, 7, 4);

    $display("[TB] pin held low after last rise");
    push_ovf(1'b0, last_rise + LAT + SAT);
    have_prev = 1'b0;
    step(SAT + 20);
    check_hold("hold_after_low_ovf", 10, 7);
    s0 = strobe_count;
    step(300);
    check_output("arm_quiet_low", strobe_count, s0);

    $display("[TB] pin stuck high after one rise");
    c = cycle;
    bus.sig_i = 1'b1;
    push_ovf(1'b1, c + LAT + SAT);
    step(SAT + 20);
    bus.sig_i = 1'b0;
    step(5);
    check_hold("hold_after_high_ovf", 10, 7);
    apply_stimulus(10, 4, 3);

    $display("[TB] period of exactly the saturation value");
    apply_stimulus(SAT, 3, 1);
    apply_stimulus(10, 4, 2);

    $display("[TB] enable dropped mid-period");
    c = cycle;
    push_valid(prev_p, prev_h, c + LAT);
    bus.sig_i = 1'b1;
    step(4);
    bus.sig_i = 1'b0;
    step(1);
    bus.en = 1'b0;
    have_prev = 1'b0;
    step(10);
    check_hold("hold_after_en_drop", 10, 4);
    bus.en = 1'b1;
    step(2);
    apply_stimulus(10, 4, 3);

    $display("[TB] enable falls on the cycle a rise is seen");
    s0 = strobe_count;
    bus.sig_i = 1'b1;
    step(LAT - 1);
    bus.en = 1'b0;
    step(4 - (LAT - 1));
    bus.sig_i = 1'b0;
    have_prev = 1'b0;
    step(10);
    check_output("en_beats_rise", strobe_count, s0);
    check_hold("hold_after_en_rise", 10, 4);
    bus.en = 1'b1;
    step(2);
    apply_stimulus(10, 4, 3);

    $display("[TB] asynchronous reset mid-measurement");
    step(2);
    #3;
    rst = 1'b0;
    #1;
    check_output("async_rst_period", 32'(bus.period_o), 0);
    check_output("async_rst_high", 32'(bus.high_o), 0);
    check_output("async_rst_valid", 32'(bus.valid_o), 0);
    check_output("async_rst_ovf", 32'(bus.ovf_o), 0);
    check_output("async_rst_level", 32'(bus.level_o), 0);
    have_prev = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);
    apply_stimulus(10, 4, 3);

    step(20);
    check_output("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
